// File: rtl/corelet_ctrl.sv
// Instruction sequencer for one corelet output tile: weight fetch, weight load,
// activation fetch, execute, then OFIFO drain into pmem, on the 35-bit bundle.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [len_bw-1:0]   n_act,
    input  logic [addr_bw-1:0]  w_base,
    input  logic [addr_bw-1:0]  x_base,
    input  logic [addr_bw-1:0]  p_base,
    input  logic                ofifo_valid,
    output logic [34:0]         inst,
    output logic                busy,
    output logic                done
);

    localparam int WL_CYC = row + col;
    localparam int CW     = (len_bw > $clog2(WL_CYC)) ? len_bw : $clog2(WL_CYC);

    typedef enum logic [2:0] {
        IDLE, WFILL, WLOAD, XFILL, EXEC, OREAD, DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [len_bw-1:0]   n_q;
    logic [addr_bw-1:0]  x_base_q;
    logic [addr_bw-1:0]  p_base_q;
    logic [addr_bw-1:0]  x_addr;
    logic [addr_bw-1:0]  p_addr;
    logic                x_cen;
    logic                l0_rd;
    logic                l0_wr;
    logic                load;
    logic                execute;
    logic                drain;
    logic [CW-1:0]       last_act;

    assign last_act = CW'(n_q) - CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            n_q      <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            x_addr   <= '0;
            p_addr   <= '0;
            x_cen    <= 1'b1;
            l0_rd    <= 1'b0;
            l0_wr    <= 1'b0;
            load     <= 1'b0;
            execute  <= 1'b0;
        end else begin
            // l0 write strobe trails every xmem read by exactly one cycle
            l0_wr <= ~x_cen;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q      <= n_act;
                        x_base_q <= x_base;
                        p_base_q <= p_base;
                        cnt      <= '0;
                        if (n_act == '0) begin
                            state <= DONE;
                        end else begin
                            state  <= WFILL;
                            x_cen  <= 1'b0;
                            x_addr <= w_base;
                        end
                    end
                end
                WFILL: begin
                    if (cnt == CW'(row - 1)) begin
                        state  <= WLOAD;
                        cnt    <= '0;
                        x_cen  <= 1'b1;
                        x_addr <= '0;
                        l0_rd  <= 1'b1;
                        load   <= 1'b1;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        x_addr <= x_addr + addr_bw'(1);
                    end
                end
                WLOAD: begin
                    if (cnt == CW'(WL_CYC - 1)) begin
                        state  <= XFILL;
                        cnt    <= '0;
                        l0_rd  <= 1'b0;
                        load   <= 1'b0;
                        x_cen  <= 1'b0;
                        x_addr <= x_base_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                XFILL: begin
                    if (cnt == last_act) begin
                        state   <= EXEC;
                        cnt     <= '0;
                        x_cen   <= 1'b1;
                        x_addr  <= '0;
                        l0_rd   <= 1'b1;
                        execute <= 1'b1;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        x_addr <= x_addr + addr_bw'(1);
                    end
                end
                EXEC: begin
                    if (cnt == last_act) begin
                        state   <= OREAD;
                        cnt     <= '0;
                        l0_rd   <= 1'b0;
                        execute <= 1'b0;
                        p_addr  <= p_base_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OREAD: begin
                    if (ofifo_valid) begin
                        if (cnt == last_act) begin
                            state  <= DONE;
                            cnt    <= '0;
                            p_addr <= '0;
                        end else begin
                            cnt    <= cnt + CW'(1);
                            p_addr <= p_addr + addr_bw'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // pmem write and OFIFO pop follow ofifo_valid within the same cycle
    assign drain = (state == OREAD) && ofifo_valid;
    assign busy  = (state != IDLE) && (state != DONE);
    assign done  = (state == DONE);

    assign inst = {2'b00, ~drain, ~drain, (drain ? p_addr : '0),
                   x_cen, 1'b1, x_addr,
                   drain, 2'b00, l0_rd, l0_wr, execute, load};

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: tile-timeline reference model compared every cycle,
// plus directed tiles with hand-computed expectations and randomized tiles.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int LW  = 8;
    localparam logic [34:0] IDLE_INST = 35'h1800C0000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [LW-1:0]  n_act = '0;
    logic [AW-1:0]  w_base = '0;
    logic [AW-1:0]  x_base = '0;
    logic [AW-1:0]  p_base = '0;
    logic           ofifo_valid = 1'b0;
    logic [34:0]    inst;
    logic           busy;
    logic           done;

    corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_act(n_act),
        .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a tile is a timeline measured from the start edge.
    bit            m_run = 1'b0;
    bit            m_done = 1'b0;
    int            m_rel = 0;
    int            m_reads = 0;
    int            m_n = 0;
    logic [AW-1:0] m_w = '0;
    logic [AW-1:0] m_x = '0;
    logic [AW-1:0] m_p = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run   <= 1'b0;
            m_done  <= 1'b0;
            m_rel   <= 0;
            m_reads <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_run) begin
            m_rel <= m_rel + 1;
            if (m_rel >= 2*ROW + COL + 2*m_n + 1 && ofifo_valid) begin
                m_reads <= m_reads + 1;
                if (m_reads + 1 == m_n) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (start) begin
            m_n     <= int'(n_act);
            m_w     <= w_base;
            m_x     <= x_base;
            m_p     <= p_base;
            m_reads <= 0;
            m_rel   <= 1;
            if (n_act == '0) m_done <= 1'b1;
            else             m_run  <= 1'b1;
        end
    end

    function automatic logic [34:0] exp_inst();
        logic [34:0] e;
        int r, xs, es, os;
        e  = IDLE_INST;
        r  = m_rel;
        xs = 2*ROW + COL + 1;
        es = xs + m_n;
        os = es + m_n;
        if (m_run) begin
            if (r >= 1 && r <= ROW) begin
                e[19]   = 1'b0;
                e[17:7] = m_w + AW'(r - 1);
            end else if (r >= xs && r < es) begin
                e[19]   = 1'b0;
                e[17:7] = m_x + AW'(r - xs);
            end
            if ((r - 1 >= 1 && r - 1 <= ROW) || (r - 1 >= xs && r - 1 < es)) e[2] = 1'b1;
            if (r > ROW && r < xs) begin e[3] = 1'b1; e[0] = 1'b1; end
            if (r >= es && r < os) begin e[3] = 1'b1; e[1] = 1'b1; end
            if (r >= os && ofifo_valid) begin
                e[6]     = 1'b1;
                e[32]    = 1'b0;
                e[31]    = 1'b0;
                e[30:20] = m_p + AW'(m_reads);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        check("model_inst", inst, exp_inst());
        check("model_busy", 35'(busy), 35'(m_run));
        check("model_done", 35'(done), 35'(m_done));
    end

    // Per-tile record, indexed by cycle number (start edge = cycle 0)
    logic [34:0] rec_inst [0:511];
    logic        rec_done [0:511];
    logic        rec_busy [0:511];
    logic        rec_valid[0:511];
    int          last_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input int n, input logic [AW-1:0] w, input logic [AW-1:0] x,
                            input logic [AW-1:0] p, input int vmode, input int ign_at);
        bit fin;
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        n_act = LW'(n); w_base = w; x_base = x; p_base = p;
        ofifo_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        last_c = 0;
        for (int c = 1; c < 400 && !fin; c++) begin
            start = 1'b0;
            if (c == ign_at) begin
                start  = 1'b1;
                n_act  = LW'($urandom_range(1, 9));
                w_base = AW'($urandom);
                x_base = AW'($urandom);
                p_base = AW'($urandom);
            end
            case (vmode)
                0:       ofifo_valid = 1'b1;
                1:       ofifo_valid = ($urandom_range(0, 3) != 0);
                default: ofifo_valid = (c >= 33 && c < 40) ? pat[c-33] : (c >= 40);
            endcase
            #1;
            rec_inst[c]  = inst;
            rec_done[c]  = done;
            rec_busy[c]  = busy;
            rec_valid[c] = ofifo_valid;
            last_c = c;
            if (m_done) fin = 1'b1;
            else        tick();
        end
        check("tile_finished", 35'(fin), 35'(1));
        start = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr, rd, bad, dn, d1, d2, ign;
        #1 reset = 1'b0;
        #3;
        check("reset_inst", inst, IDLE_INST);
        check("reset_busy", 35'(busy), 35'(0));
        check("reset_done", 35'(done), 35'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Full sequence
        run_tile(4, 11'h010, 11'h020, 11'h030, 0, 0);
        check("full_c1_cen_x", 35'(rec_inst[1][19]), 35'(0));
        check("full_c1_axmem", 35'(rec_inst[1][17:7]), 35'h010);
        check("full_c8_axmem", 35'(rec_inst[8][17:7]), 35'h017);
        check("full_c9_load",  35'(rec_inst[9][0]), 35'(1));
        check("full_c9_l0wr",  35'(rec_inst[9][2]), 35'(1));
        check("full_c24_load", 35'(rec_inst[24][0]), 35'(1));
        check("full_c25_load", 35'(rec_inst[25][0]), 35'(0));
        check("full_c25_axmem", 35'(rec_inst[25][17:7]), 35'h020);
        check("full_c28_axmem", 35'(rec_inst[28][17:7]), 35'h023);
        check("full_c29_exec", 35'(rec_inst[29][1]), 35'(1));
        check("full_c29_l0wr", 35'(rec_inst[29][2]), 35'(1));
        check("full_c32_exec", 35'(rec_inst[32][1]), 35'(1));
        check("full_c33_apmem", 35'(rec_inst[33][30:20]), 35'h030);
        check("full_c33_wen_p", 35'(rec_inst[33][31]), 35'(0));
        check("full_c36_apmem", 35'(rec_inst[36][30:20]), 35'h033);
        check("full_done_cycle", 35'(last_c), 35'd37);
        check("full_done_c37", 35'(rec_done[37]), 35'(1));

        // Stalled drain
        run_tile(4, 11'h010, 11'h020, 11'h030, 2, 0);
        wr = 0; rd = 0; bad = 0;
        for (int c = 1; c <= last_c; c++) begin
            if (rec_inst[c][6]) rd++;
            if (rec_inst[c][32] == 1'b0) begin
                if (!rec_valid[c]) bad++;
                check("stall_apmem", 35'(rec_inst[c][30:20]), 35'(11'h030 + AW'(wr)));
                wr++;
            end
        end
        check("stall_writes", 35'(wr), 35'd4);
        check("stall_reads", 35'(rd), 35'd4);
        check("stall_write_wo_valid", 35'(bad), 35'd0);
        check("stall_done_cycle", 35'(last_c), 35'd40);

        // Zero length
        run_tile(0, 11'h111, 11'h222, 11'h333, 0, 0);
        check("zero_done_cycle", 35'(last_c), 35'd1);
        check("zero_done", 35'(rec_done[1]), 35'(1));
        check("zero_busy", 35'(rec_busy[1]), 35'(0));
        check("zero_inst", rec_inst[1], IDLE_INST);

        // Address wrap, plus an ignored start during EXEC
        run_tile(3, 11'h7FC, 11'h100, 11'h200, 0, 29);
        check("wrap_c4_axmem", 35'(rec_inst[4][17:7]), 35'h7FF);
        check("wrap_c5_axmem", 35'(rec_inst[5][17:7]), 35'h000);
        check("wrap_c8_axmem", 35'(rec_inst[8][17:7]), 35'h003);
        check("ign_c31_apmem", 35'(rec_inst[31][30:20]), 35'h200);
        check("ign_done_cycle", 35'(last_c), 35'd34);

        // Asynchronous reset mid-WLOAD
        n_act = 8'd3; w_base = 11'h040; x_base = 11'h050; p_base = 11'h060;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        #1;
        check("pre_reset_load", 35'(inst[0]), 35'(1));
        reset = 1'b0;
        #1;
        check("async_reset_inst", inst, IDLE_INST);
        check("async_reset_busy", 35'(busy), 35'(0));
        check("async_reset_done", 35'(done), 35'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        run_tile(2, 11'h040, 11'h050, 11'h060, 0, 0);
        check("post_reset_c1_axmem", 35'(rec_inst[1][17:7]), 35'h040);
        check("post_reset_c1_cen_x", 35'(rec_inst[1][19]), 35'(0));
        check("post_reset_done_cycle", 35'(last_c), 35'd31);

        // Back-to-back with start held high
        n_act = 8'd2; w_base = 11'h080; x_base = 11'h090; p_base = 11'h0A0;
        start = 1'b1;
        tick();
        dn = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 70; c++) begin
            if (c == 34) start = 1'b0;
            ofifo_valid = 1'b1;
            #1;
            if (done) begin
                dn++;
                if (dn == 1) d1 = c;
                else         d2 = c;
            end
            if (c == 33) begin
                check("b2b_c33_axmem", 35'(inst[17:7]), 35'h080);
                check("b2b_c33_cen_x", 35'(inst[19]), 35'(0));
            end
            tick();
        end
        check("b2b_done_count", 35'(dn), 35'd2);
        check("b2b_done1_cycle", 35'(d1), 35'd31);
        check("b2b_done2_cycle", 35'(d2), 35'd63);

        // Randomized tiles
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(0, 7);
            ign = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 2*ROW + COL + n) : 0;
            run_tile(n, AW'($urandom), AW'($urandom), AW'($urandom), 1, ign);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
